// File: rtl/ysyx_24120013_ifu.sv
// Instruction fetch unit: one outstanding imem read, valid/ready hand-off to decode,
// sequential PC with execute redirect that discards in-flight fetches.
module ysyx_24120013_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  IFU_valid,
    input  logic                  IDU_ready,
    output logic [INST_WIDTH-1:0] IFU_inst,
    output logic [ADDR_WIDTH-1:0] IFU_pc,
    output logic                  IFU_fault
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    drop_q, drop_d;
    logic                    valid_q, valid_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
    logic                    fault_q, fault_d;

    logic redir, redir_bad, redir_ok, req_fire;

    // Gate with rst so the request drops the instant reset is asserted.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign redir     = redirect_valid && (state_q != S_HALT);
    assign redir_bad = redir && (redirect_pc[1:0] != 2'b00);
    assign redir_ok  = redir && !redir_bad;

    assign IFU_valid = valid_q;
    assign IFU_inst  = inst_q;
    assign IFU_pc    = ipc_q;
    assign IFU_fault = fault_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        unique case (state_q)
            S_REQ: begin
                if (redir_ok) pc_d = redirect_pc;
                if (req_fire) begin
                    state_d = S_WAIT;
                    drop_d  = redir_ok;
                end
            end
            S_WAIT: begin
                if (redir_ok) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (imem_resp_err) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        inst_d  = imem_resp_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redir_ok) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (IDU_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_HALT: ;
        endcase
        // A misaligned target halts from any live state, overriding the above.
        if (redir_bad) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            state_d = S_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// Directed bench for the fetch unit; memory and decode are driven cycle by cycle.
module tb_ysyx_24120013_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        IFU_valid;
    logic        IDU_ready = 1'b0;
    logic [31:0] IFU_inst;
    logic [31:0] IFU_pc;
    logic        IFU_fault;

    int vectors = 0;
    int miscompares = 0;

    ysyx_24120013_ifu dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .IFU_valid(IFU_valid), .IDU_ready(IDU_ready),
        .IFU_inst(IFU_inst), .IFU_pc(IFU_pc), .IFU_fault(IFU_fault)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0; IDU_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        vectors++; if (IFU_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ifu_valid got %b want 0", IFU_valid); end
        vectors++; if (IFU_inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst got %h want 0", IFU_inst); end
        vectors++; if (IFU_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", IFU_pc); end
        vectors++; if (IFU_fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %b want 0", IFU_fault); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_first_req got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1; IDU_ready = 1'b1;
        tick();
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL basic_wait_noreq got %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b1 || IFU_inst !== 32'h0010_0093 || IFU_pc !== 32'h8000_0000) begin miscompares++; $display("FAIL basic_out got v=%b i=%h p=%h want v=1 i=00100093 p=80000000", IFU_valid, IFU_inst, IFU_pc); end
        tick();
        vectors++; if (IFU_valid !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle got %b want 0", IFU_valid); end
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL basic_next_req got v=%b a=%h want v=1 a=80000004", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_backpressure();
        IDU_ready = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (IFU_valid !== 1'b1 || IFU_inst !== 32'h0020_0113 || IFU_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d] got v=%b i=%h p=%h rq=%b want v=1 i=00200113 p=80000004 rq=0", i, IFU_valid, IFU_inst, IFU_pc, imem_req_valid); end
            tick();
        end
        IDU_ready = 1'b1;
        tick();
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin miscompares++; $display("FAIL bp_next_req got v=%b a=%h want v=1 a=80000008", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b0) begin miscompares++; $display("FAIL rw_stale_hidden got %b want 0", IFU_valid); end
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin miscompares++; $display("FAIL rw_next_req got v=%b a=%h want v=1 a=80000100", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_out();
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b1 || IFU_pc !== 32'h8000_0100) begin miscompares++; $display("FAIL ro_out got v=%b p=%h want v=1 p=80000100", IFU_valid, IFU_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; IDU_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b0 || imem_req_addr !== 32'h8000_0200) begin miscompares++; $display("FAIL ro_target got v=%b a=%h want v=0 a=80000200", IFU_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_req();
        // Handshake and redirect together: old address goes out, its response is dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin miscompares++; $display("FAIL rq_hs_drop got v=%b rq=%b a=%h want v=0 rq=1 a=80000300", IFU_valid, imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin miscompares++; $display("FAIL rq_nohs got v=%b a=%h want v=1 a=80000400", imem_req_valid, imem_req_addr); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_valid !== 1'b0 || imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rq_resp_ignored got v=%b rq=%b want v=0 rq=1", IFU_valid, imem_req_valid); end
    endtask

    task automatic test_resp_err();
        do_reset();
        imem_req_ready = 1'b1; IDU_ready = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
        tick();
        imem_resp_valid = 1'b0;
        tick();
        vectors++; if (imem_req_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL err_second_addr got %h want 80000004", imem_req_addr); end
        tick();
        imem_resp_valid = 1'b1; imem_resp_err = 1'b1;
        tick();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        vectors++; if (IFU_fault !== 1'b1 || IFU_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL err_halt got f=%b v=%b rq=%b want f=1 v=0 rq=0", IFU_fault, IFU_valid, imem_req_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        tick();
        vectors++; if (IFU_fault !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL err_redir_ignored got f=%b rq=%b want f=1 rq=0", IFU_fault, imem_req_valid); end
        do_reset();
        #1;
        vectors++; if (IFU_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL err_rst_clear got f=%b rq=%b a=%h want f=0 rq=1 a=80000000", IFU_fault, imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_misaligned();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (IFU_fault !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mis_halt got f=%b rq=%b want f=1 rq=0", IFU_fault, imem_req_valid); end
        tick();
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mis_stays got rq=%b want 0", imem_req_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        vectors++; if (imem_req_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got %h want fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1; IDU_ready = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        tick();
        imem_resp_valid = 1'b0;
        vectors++; if (IFU_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_ifu_pc got %h want fffffffc", IFU_pc); end
        tick();
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_next got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_out();
        test_redirect_req();
        test_resp_err();
        test_misaligned();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_24120013_ifu.md
Name: ysyx_24120013_ifu

Overview:
Instruction fetch unit sitting directly upstream of the decode stage.
- Holds the PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Accepts the memory response and presents the 32-bit instruction plus its PC to decode through a valid/ready handshake.
- Advances the PC sequentially; a redirect input from execute can override it at any time, and in-flight fetches are discarded.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INST_WIDTH, 32, instruction width
RESET_PC, 32'h8000_0000, PC value after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  one-cycle pulse: replace PC with redirect_pc
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address (= current PC)
imem_resp_valid  in  1  read data valid (single-cycle pulse)
imem_resp_data  in  INST_WIDTH  read data
imem_resp_err  in  1  access fault, qualified by imem_resp_valid
IFU_valid  out  1  IFU_inst/IFU_pc valid to decode
IDU_ready  in  1  decode accepts instruction
IFU_inst  out  INST_WIDTH  fetched instruction
IFU_pc  out  ADDR_WIDTH  PC of IFU_inst
IFU_fault  out  1  sticky fetch fault flag

Behaviour:
- Reset (async, rst=1) forces these values:
  - state=S_REQ, pc=RESET_PC, drop=0.
  - IFU_valid=0, IFU_inst=0, IFU_pc=0, IFU_fault=0.
  - imem_req_valid deasserts immediately while rst=1.
  - Reset mid-transaction abandons it; memory sees no further handshake from the old request.
- FSM, four states; exactly one request outstanding:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&&req_ready, go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_resp_valid:
    - If drop=1: discard the data, clear drop, go to S_REQ.
    - Else if imem_resp_err: set IFU_fault, go to S_HALT.
    - Else: register IFU_inst=resp_data and IFU_pc=pc, set IFU_valid, go to S_OUT.
  - S_OUT: IFU_valid=1; IFU_inst and IFU_pc are held stable. On IFU_valid&&IDU_ready, set pc=pc+4, clear IFU_valid, go to S_REQ.
  - S_HALT: no requests, IFU_valid=0. Only reset exits this state.
- Latency and throughput:
  - Response in cycle M puts IFU_valid high at M+1.
  - Best case: 3 cycles per instruction with a zero-wait memory.
- PC arithmetic: pc+4 is modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC wraps to 0.
- Redirect (redirect_valid=1) has the highest priority except in S_HALT, where it is ignored.
  - In S_REQ with no handshake that cycle: pc=redirect_pc, stay in S_REQ. The address changes while valid is high; memory must tolerate this.
  - In S_REQ with a handshake in the same cycle: the old address is accepted. Set pc=redirect_pc and drop=1, go to S_WAIT.
  - In S_WAIT without resp_valid: pc=redirect_pc, drop=1.
  - In S_WAIT with resp_valid in the same cycle: discard the response, including any resp_err. Set pc=redirect_pc, go to S_REQ.
  - In S_OUT: IFU_valid clears next cycle, pc=redirect_pc, go to S_REQ.
    - If IDU_ready is also high, the instruction counts as consumed, but pc takes redirect_pc, not pc+4.
- redirect_pc with bits[1:0]≠0 sets IFU_fault and enters S_HALT. No request is issued.
- imem_resp_valid outside S_WAIT is ignored.
- IFU_valid never deasserts without a handshake, except on redirect or reset.

Test Plan:
- Reset, then memory with ready=1 and a 1-cycle response returning 0x00100093, IDU_ready=1 → req_addr=0x8000_0000; IFU_valid for one cycle with IFU_inst=0x00100093 and IFU_pc=0x8000_0000; next req_addr=0x8000_0004.
- Backpressure: IDU_ready=0 for 5 cycles → IFU_valid stays 1 with inst and pc unchanged, no new request; after IDU_ready=1, the next request uses pc+4.
- Redirect to 0x8000_0100 while in S_WAIT; the stale response 0xDEADBEEF arrives 3 cycles later → it is never presented; the next req_addr is 0x8000_0100.
- Redirect in the same cycle as the S_OUT handshake → IFU_valid drops; next req_addr is redirect_pc, not pc+4.
- resp_err=1 on the 2nd fetch → IFU_fault=1, no further requests; a redirect is ignored; rst clears the fault.
- redirect_pc=0x8000_0002 → IFU_fault=1 and S_HALT; PC at 0xFFFF_FFFC wraps the next fetch to 0x0000_0000.
